// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample loader.
//   ADDR_W_DEF / DATA_W_DEF / FIFO_DEPTH_DEF : default widths and buffer depth
//   CSUM_W                                   : width of the write checksum
//   loader_state_t                           : loader FSM state encoding
package fir_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CSUM_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_KICK      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/fir_loader_fifo.sv
// Small synchronous FIFO buffering incoming samples ahead of the memory port.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : empties the FIFO (overrides push/pop that cycle)
//   push, push_data   : write an entry (ignored when full)
//   pop               : retire the head entry (ignored when empty)
//   head_data         : current head entry
//   full, empty       : occupancy flags
module fir_loader_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] store [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign head_data = store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fir_sample_loader.sv
// Loads a run of signed samples into the FIR sample memory, then kicks the
// FIR core and reports completion.
// Optional feature: define FIR_LOADER_CHECKSUM_EN to get a running 16-bit sum
// of the sign-extended samples written this run; otherwise checksum is 0.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   arm, cfg_base_addr,
//   cfg_count                 : start a run (IDLE only, count must be nonzero)
//   abort                     : cancel the run from any state
//   in_valid, in_data,
//   in_ready                  : upstream sample handshake
//   mem_we, mem_addr, mem_data: registered sample memory write port
//   fir_start, fir_done       : FIR core kick pulse / completion level
//   busy, load_done           : run in progress / end-of-run pulse
//   checksum                  : sum of written samples (see above)
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for arm with a nonzero count
// ST_LOAD    | accepting samples and draining them into sample memory
// ST_KICK    | fir_start high for this single cycle
// ST_WAIT_DONE | waiting for fir_done, then pulse load_done
module fir_sample_loader
  import fir_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              fir_start,
  input  logic              fir_done,
  output logic              busy,
  output logic              load_done,
  output logic [CSUM_W-1:0] checksum
);

  loader_state_t     state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] accepted_q;
  logic [ADDR_W-1:0] written_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] head_data;
  logic              push;
  logic              pop;
  logic              arm_go;

  assign arm_go   = (state == ST_IDLE) && arm && (cfg_count != '0) && !abort;
  // Abort suppresses the handshake so a sample offered that cycle is dropped.
  assign in_ready = (state == ST_LOAD) && !fifo_full && (accepted_q < count_q) && !abort;
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_LOAD) && !fifo_empty && !abort;
  assign busy     = (state != ST_IDLE);

  fir_loader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      fir_start  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      fir_start <= 1'b0;
      load_done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm_go) begin
              base_q     <= cfg_base_addr;
              count_q    <= cfg_count;
              accepted_q <= '0;
              written_q  <= '0;
              state      <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (push) accepted_q <= accepted_q + 1'b1;
            if (pop) begin
              mem_we    <= 1'b1;
              // Natural ADDR_W overflow gives the wrap from top of memory to 0.
              mem_addr  <= base_q + written_q;
              mem_data  <= head_data;
              written_q <= written_q + 1'b1;
            end else if (written_q == count_q) begin
              // No pop implies the FIFO is empty, so the run is fully written.
              fir_start <= 1'b1;
              state     <= ST_KICK;
            end
          end
          ST_KICK: begin
            // fir_done may still be high from the previous run; not sampled here.
            state <= ST_WAIT_DONE;
          end
          ST_WAIT_DONE: begin
            if (fir_done) begin
              load_done <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FIR_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q;

  // Updated on the same edge that loads mem_data, so it tracks the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (arm_go) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q + {{(CSUM_W-DATA_W){head_data[DATA_W-1]}}, head_data};
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule
